// File: rtl/ehl_cdc.sv
`default_nettype none
// ============================================================================
// Module      : ehl_cdc
// Description : Multi-stage flop synchroniser for asynchronous inputs.
//               NUM_STAGES = 0 passes the input straight through for
//               signals that are already synchronous to clk.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1      destination clock
//   reset_n   in   1      asynchronous, active-low reset of the flop chain
//   data_in   in   WIDTH  asynchronous input
//   data_out  out  WIDTH  synchronised output
// ============================================================================
module ehl_cdc #(
    parameter int TECHNOLOGY = 0,
    parameter int NUM_STAGES = 3,
    parameter int WIDTH      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    if (NUM_STAGES == 0) begin : g_bypass
        assign data_out = data_in;
    end else begin : g_sync
        // TECHNOLOGY selects a vendor synchroniser cell; only the generic
        // flop chain is available in this library.
        case (TECHNOLOGY)
            default: begin : g_generic
                logic [WIDTH-1:0] r_stage [NUM_STAGES];

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        for (int s = 0; s < NUM_STAGES; s++) begin
                            r_stage[s] <= '0;
                        end
                    end else begin
                        r_stage[0] <= data_in;
                        for (int s = 1; s < NUM_STAGES; s++) begin
                            r_stage[s] <= r_stage[s-1];
                        end
                    end
                end

                assign data_out = r_stage[NUM_STAGES-1];
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ehl_gpio_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : ehl_gpio_debounce_cell
// Description : One GPIO debounce channel. Holds the filtered level, the
//               stability counter and the registered edge pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1      clock
//   reset    in   1      asynchronous, active-high reset
//   tick     in   1      shared sample strobe from the prescaler
//   flt_len  in   CNT_W  filter length N (accept after N+1 differing samples)
//   gfmr     in   1      1 = debounce, 0 = bypass (follow dsync every clock)
//   dsync    in   1      synchronised pin level
//   state    out  1      filtered level (registered)
//   rise     out  1      one-cycle pulse coinciding with state 0->1
//   fall     out  1      one-cycle pulse coinciding with state 1->0
// ============================================================================
module ehl_gpio_debounce_cell #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] flt_len,
    input  logic             gfmr,
    input  logic             dsync,
    output logic             state,
    output logic             rise,
    output logic             fall
);

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic             w_next_state;
    logic [CNT_W-1:0] w_next_cnt;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (!gfmr) begin
            // Bypass: follow the pin and keep the counter parked at zero so
            // that re-enabling the filter starts a fresh count.
            w_next_state = dsync;
            w_next_cnt   = '0;
        end else if (tick) begin
            if (dsync == r_state) begin
                w_next_cnt = '0;
            end else if (r_cnt >= flt_len) begin
                // >= rather than == so that lowering flt_len below the
                // running count accepts at once instead of wrapping.
                w_next_state = dsync;
                w_next_cnt   = '0;
            end else begin
                w_next_cnt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_rise  <= w_next_state & ~r_state;
            r_fall  <= ~w_next_state & r_state;
        end
    end

    assign state = r_state;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ehl_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ehl_gpio_debounce
// Description : Per-channel GPIO input debouncer with programmable filter
//               length and a sample prescaler shared by all channels.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1        clock
//   reset     in   1        asynchronous, active-high reset
//   gfmr      in   WIDTH    per-channel filter enable (0 = bypass)
//   flt_len   in   CNT_W    filter length N
//   presc     in   PRESC_W  sample period P (tick every P+1 clocks)
//   data_in   in   WIDTH    asynchronous pin inputs
//   data_out  out  WIDTH    filtered levels
//   rise      out  WIDTH    rising-edge pulses
//   fall      out  WIDTH    falling-edge pulses
// ============================================================================
module ehl_gpio_debounce #(
    parameter int               WIDTH          = 32,
    parameter int               CNT_W          = 4,
    parameter int               PRESC_W        = 8,
    parameter int               CDC_TECHNOLOGY = 0,
    parameter logic [WIDTH-1:0] META_ENA       = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   gfmr,
    input  logic [CNT_W-1:0]   flt_len,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic [WIDTH-1:0]   rise,
    output logic [WIDTH-1:0]   fall
);

    localparam int c_SYNC_STAGES = 3;

    logic               w_reset_n;
    logic [WIDTH-1:0]   w_dsync;
    logic [PRESC_W-1:0] r_pcnt;
    logic               w_tick;

    assign w_reset_n = ~reset;

    // >= so that lowering presc below the running count ticks on the next
    // clock instead of waiting for the counter to wrap.
    assign w_tick = (r_pcnt >= presc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        ehl_cdc #(
            .TECHNOLOGY (CDC_TECHNOLOGY),
            .NUM_STAGES (META_ENA[i] ? c_SYNC_STAGES : 0),
            .WIDTH      (1)
        ) u_cdc (
            .clk      (clk),
            .reset_n  (w_reset_n),
            .data_in  (data_in[i]),
            .data_out (w_dsync[i])
        );

        ehl_gpio_debounce_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .tick    (w_tick),
            .flt_len (flt_len),
            .gfmr    (gfmr[i]),
            .dsync   (w_dsync[i]),
            .state   (data_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_ehl_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_ehl_gpio_debounce
// Description : Self-checking bench for ehl_gpio_debounce. A cycle model
//               pushes expected outputs into a queue at each rising edge;
//               they are popped and compared on the falling edge. Directed
//               latency checks run alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ehl_gpio_debounce;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gfmr;
    logic [3:0]  flt_len;
    logic [7:0]  presc;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [31:0] rise;
    logic [31:0] fall;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ehl_gpio_debounce #(
        .WIDTH          (32),
        .CNT_W          (4),
        .PRESC_W        (8),
        .CDC_TECHNOLOGY (0),
        .META_ENA       (32'hFFFF_FFFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .gfmr     (gfmr),
        .flt_len  (flt_len),
        .presc    (presc),
        .data_in  (data_in),
        .data_out (data_out),
        .rise     (rise),
        .fall     (fall)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [95:0] sb_q[$];
    logic [31:0] m_s1, m_s2, m_s3, m_st, m_rise, m_fall;
    int          m_cnt [32];
    int          m_pcnt;

    always @(posedge clk) begin
        logic [31:0] nxt;
        bit          tk;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_s3 = '0;
            m_st = '0; m_rise = '0; m_fall = '0;
            m_pcnt = 0;
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            tk  = (m_pcnt >= int'(presc));
            nxt = m_st;
            for (int i = 0; i < 32; i++) begin
                if (!gfmr[i]) begin
                    nxt[i]   = m_s3[i];
                    m_cnt[i] = 0;
                end else if (tk) begin
                    if (m_s3[i] == m_st[i]) begin
                        m_cnt[i] = 0;
                    end else if (m_cnt[i] >= int'(flt_len)) begin
                        nxt[i]   = m_s3[i];
                        m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_rise = nxt & ~m_st;
            m_fall = ~nxt & m_st;
            m_st   = nxt;
            m_s3   = m_s2;
            m_s2   = m_s1;
            m_s1   = data_in;
            m_pcnt = tk ? 0 : m_pcnt + 1;
        end
        sb_q.push_back({m_st, m_rise, m_fall});
    end

    always @(negedge clk) begin
        logic [95:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_data_out", data_out, e[95:64]);
            chk("sb_rise",     rise,     e[63:32]);
            chk("sb_fall",     fall,     e[31:0]);
            chk("rise_fall_excl", rise & fall, 32'h0);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    // Toggle data_in[ch]; toggle it back after len clocks (len=0: step).
    // Reports clocks from the toggle until data_out[ch] first changes
    // (-1 if never within the window) and the edge pulses seen.
    task automatic pulse_watch(input int ch, input int len,
                               output int lat, output int nrise, output int nfall);
        logic start;
        start = data_out[ch];
        lat   = -1;
        nrise = 0;
        nfall = 0;
        @(negedge clk);
        data_in[ch] = ~data_in[ch];
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (lat < 0 && data_out[ch] != start) lat = n;
            nrise += int'(rise[ch]);
            nfall += int'(fall[ch]);
            if (n == len) data_in[ch] = ~data_in[ch];
        end
    endtask

    int lat, nr, nf;

    initial begin
        reset   = 1'b1;
        gfmr    = '0;
        flt_len = '0;
        presc   = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Reset with all inputs high: outputs clear at once, no fall pulse.
        data_in = 32'hFFFF_FFFF;
        repeat (6) @(negedge clk);
        chk("pre_rst_dout", data_out, 32'hFFFF_FFFF);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_dout", data_out, 32'h0);
        chk("rst_rise", rise, 32'h0);
        chk("rst_fall", fall, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_fall", fall, 32'h0);
        end
        data_in = '0;
        reset   = 1'b0;
        repeat (6) @(negedge clk);

        // Bypass on channel 0.
        gfmr = '0;
        pulse_watch(0, 0, lat, nr, nf);
        chk("byp_rise_lat", lat, 4);
        chk("byp_rise_cnt", nr, 1);
        chk("byp_rise_nofall", nf, 0);
        pulse_watch(0, 0, lat, nr, nf);
        chk("byp_fall_lat", lat, 4);
        chk("byp_fall_cnt", nf, 1);

        // Glitch rejection on channel 5, N=3, P=0.
        gfmr    = 32'h0000_0020;
        flt_len = 4'd3;
        presc   = 8'd0;
        repeat (2) @(negedge clk);
        pulse_watch(5, 3, lat, nr, nf);
        chk("glitch3_lat", lat, -1);
        chk("glitch3_rise", nr, 0);
        pulse_watch(5, 4, lat, nr, nf);
        chk("pulse4_lat", lat, 7);
        chk("pulse4_rise", nr, 1);
        chk("pulse4_fall", nf, 1);

        // Prescaler on channel 7, N=1, P=4.
        gfmr    = 32'h0000_0080;
        flt_len = 4'd1;
        presc   = 8'd4;
        repeat (2) @(negedge clk);
        pulse_watch(7, 0, lat, nr, nf);
        chk("presc_lat_range", (lat >= 9 && lat <= 13), 1);
        chk("presc_rise", nr, 1);
        pulse_watch(7, 3, lat, nr, nf);
        chk("presc_glitch_lat", lat, -1);
        chk("presc_glitch_fall", nf, 0);

        // flt_len lowered 15 -> 2 with cnt = 7 on channel 9.
        gfmr    = 32'h0000_0200;
        flt_len = 4'd15;
        presc   = 8'd0;
        repeat (3) @(negedge clk);
        lat = -1;
        @(negedge clk);
        data_in[9] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (lat < 0 && data_out[9]) lat = n;
            if (n == 10) flt_len = 4'd2;
        end
        chk("dyn_flt_lat", lat, 11);

        // presc lowered 200 -> 0 with pcnt = 100 on channel 11, N=0.
        @(negedge clk);
        #2 reset = 1'b1;
        gfmr        = 32'h0000_0800;
        flt_len     = 4'd0;
        presc       = 8'd200;
        data_in[11] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat = -1;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (lat < 0 && data_out[11]) lat = n;
            if (n == 100) presc = 8'd0;
        end
        chk("dyn_presc_lat", lat, 101);

        // Random bounce on all channels; scoreboard checks every cycle.
        for (int blk = 0; blk < 8; blk++) begin
            @(negedge clk);
            gfmr    = $urandom;
            flt_len = 4'($urandom_range(0, 3));
            presc   = 8'($urandom_range(0, 2));
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                data_in = data_in ^ ($urandom & $urandom & $urandom);
            end
        end
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ehl_gpio_debounce.md
# ehl_gpio_debounce

- Parametrised per-channel GPIO input debouncer with a programmable filter length and a shared sample prescaler.
- Replaces the fixed three-sample filter in the GPIO input path.
- Synchronises each pin into `clk`, then accepts a new level only after it has been stable for a programmable number of prescaled samples.
- Emits registered rise/fall event pulses for the GPIO interrupt logic.

## Interface

Parameters:
- `WIDTH`, 32: number of GPIO channels.
- `CNT_W`, 4: width of the filter-length field and of each per-channel stability counter.
- `PRESC_W`, 8: width of the sample prescaler.
- `CDC_TECHNOLOGY`, 0: passed to `ehl_cdc`.
- `META_ENA`, 32'hFFFFFFFF: per-bit enable for the synchroniser.
  - Bit set: 3-stage synchroniser.
  - Bit clear: 0 stages, i.e. the pin is already synchronous.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `gfmr`  in  WIDTH  per-channel filter enable.
  - 0: bypass; the synchronised input is registered every clock.
  - 1: debounce.
- `flt_len`  in  CNT_W  shared filter length N. A new level is accepted after N+1 consecutive differing samples.
- `presc`  in  PRESC_W  sample period P. A sample tick occurs every P+1 clocks.
- `data_in`  in  WIDTH  asynchronous pin inputs.
- `data_out`  out  WIDTH  filtered level (registered).
- `rise`  out  WIDTH  one-cycle pulse when `data_out[i]` goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse when `data_out[i]` goes 1→0.

## Operation

- **Synchroniser:** `dsync[i]` = `data_in[i]` through `ehl_cdc`. Its `reset_n` is driven by `~reset`.
- **Prescaler:**
  - `pcnt` counts up from 0.
  - `tick` = (`pcnt` >= `presc`). On `tick`, `pcnt` <= 0; otherwise `pcnt` <= `pcnt`+1.
  - `presc`=0 gives a tick every clock.
  - Using >= (not ==) means lowering `presc` below `pcnt` ticks on the next clock, with no wrap-around.
- **Channel with `gfmr[i]`=1**, evaluated on `tick` only; between ticks it holds:
  - `dsync[i]` == `state[i]`: `cnt[i]` <= 0.
  - Otherwise, if `cnt[i]` >= `flt_len`: `state[i]` <= `dsync[i]` and `cnt[i]` <= 0.
  - Otherwise: `cnt[i]` <= `cnt[i]`+1. The >= compare keeps the counter from overflowing when `flt_len` is lowered mid-count.
- **Channel with `gfmr[i]`=0:** `state[i]` <= `dsync[i]` every clock and `cnt[i]` <= 0.
  - Changing `gfmr[i]` never forces a change of `state[i]`.
  - Filtering restarts from `cnt`=0.
- **Outputs:**
  - `data_out` = `state`.
  - `rise[i]` <= next_state & ~state; `fall[i]` <= ~next_state & state. Both are registered, so each pulse coincides with the `data_out` change.
- **Reset:** asynchronous clear of `state`, `cnt`, `pcnt`, `rise`, `fall`, and the synchroniser flops. A reset-forced 1→0 on `data_out` produces no `fall` pulse.

## Timing

- **Reset values:** `data_out`=0, `rise`=0, `fall`=0.
- **Synchroniser latency:** S = 3 clocks, or 0 where `META_ENA[i]`=0.
- **Bypass:** `data_out` follows `data_in` after S+1 clocks.
- **Filter, P=0:** a stable change on `dsync` appears on `data_out` exactly N+1 clocks later.
  - A pulse of N clocks or fewer on `dsync` never reaches the output.
  - N=0 behaves as bypass with a 1-clock delay.
- **Filter, P>0:** latency is N+1 ticks, plus 0..P clocks of tick phase.
  - `dsync` is observed only at ticks; glitches between ticks are invisible.
- **Simultaneous events:** per-channel behaviour is independent. All channels share the same tick.
- **Maximum rate:** at most one `rise` or `fall` per channel per tick. In bypass, at most one per clock.

## Structure

- No shared package. All constants are module parameters.
- Top level instantiates `ehl_cdc` per bit, as the existing GPIO input path does.
- One natural sub-module, `ehl_gpio_debounce_cell`.
  - Instantiated per channel, inside a generate loop.
  - Contains `state`, `cnt` and edge logic.
  - Inputs: `tick`, `flt_len`, `gfmr[i]`, `dsync[i]`.
- The prescaler lives in the top level, shared by all cells.

## Test plan

- **Reset:** assert `reset` with `data_in`=all ones. Required: `data_out`, `rise` and `fall` all 0 immediately; no `fall` pulse at reset.
- **Bypass:** `gfmr`=0, `META_ENA` bit set, toggle `data_in[0]`. Required: `data_out[0]` follows 4 clocks later, with one `rise` or `fall` per edge.
- **Glitch reject, `flt_len`=3, `presc`=0:**
  - 3-clock high pulse on `dsync[5]`: no output change, no events.
  - 4-clock pulse: `data_out[5]` rises 4 clocks after `dsync`, with a single `rise[5]` pulse.
- **Prescaler, `presc`=4, `flt_len`=1:** a stable 1 reaches `data_out` after 2 ticks (6..10 clocks). A 3-clock pulse placed between ticks is ignored.
- **Dynamic reprogramming:**
  - Drop `flt_len` 15→2 while `cnt`=7: accept occurs at the next tick.
  - Drop `presc` 200→0 while `pcnt`=100: tick occurs the next clock.
- **Per-channel independence:** all 32 channels driven with random bounce. Required: `data_out` matches the reference model, and `rise`/`fall` are never both high on one channel.
